// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: IDLE/FETCH/HOLD handshake with retry timeout.
// Optional delay-slot redirects enabled by FETCH_CTRL_DELAY_SLOT_EN.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic        if_valid,
  output logic [31:0] if_ins,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  input  logic        br_taken,
  input  logic [15:0] br_imm,
  input  logic        jmp,
  input  logic [25:0] jmp_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        fetch_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } state_t;

  state_t        state, state_d;
  logic [31:0]   pc, pc_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          err_d;
  logic          valid_d;
  logic [31:0]   ins_d, ipc_d;
  logic [31:0]   seq, br_off, tgt;
  logic          redir;
  logic          unused_bits;

`ifdef FETCH_CTRL_DELAY_SLOT_EN
  logic          pend, pend_d;
  logic [31:0]   pend_pc, pend_pc_d;
`endif

  assign unused_bits = ^{jr_target[1:0], flush_pc[1:0]};

  assign im_req  = (state == FETCH);
  assign im_addr = {pc[31:2], 2'b00};

  assign seq    = if_pc + 32'd4;
  assign br_off = {{14{br_imm[15]}}, br_imm, 2'b00};
  assign redir  = jr | jmp | br_taken;

  // jr wins over jmp, jmp over branch
  always_comb begin
    tgt = seq;
    if (jr)
      tgt = {jr_target[31:2], 2'b00};
    else if (jmp)
      tgt = {seq[31:28], jmp_target, 2'b00};
    else if (br_taken)
      tgt = seq + br_off;
  end

  always_comb begin
    state_d   = state;
    pc_d      = pc;
    cnt_d     = cnt;
    err_d     = 1'b0;
    valid_d   = if_valid;
    ins_d     = if_ins;
    ipc_d     = if_pc;
`ifdef FETCH_CTRL_DELAY_SLOT_EN
    pend_d    = pend;
    pend_pc_d = pend_pc;
`endif
    if (flush) begin
      state_d = FETCH;
      pc_d    = {flush_pc[31:2], 2'b00};
      cnt_d   = '0;
      valid_d = 1'b0;
`ifdef FETCH_CTRL_DELAY_SLOT_EN
      pend_d  = 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          state_d = FETCH;
          cnt_d   = '0;
        end
        FETCH: begin
          if (im_ack) begin
            ins_d   = im_rdata;
            ipc_d   = pc;
            valid_d = 1'b1;
            state_d = HOLD;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        HOLD: begin
          if (id_ready) begin
            valid_d = 1'b0;
            state_d = IDLE;
`ifdef FETCH_CTRL_DELAY_SLOT_EN
            // the delay slot itself never redirects
            if (pend) begin
              pc_d   = pend_pc;
              pend_d = 1'b0;
            end else if (redir) begin
              pend_d    = 1'b1;
              pend_pc_d = tgt;
              pc_d      = seq;
            end else begin
              pc_d = seq;
            end
`else
            pc_d = redir ? tgt : seq;
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      cnt       <= '0;
      fetch_err <= 1'b0;
      if_valid  <= 1'b0;
      if_ins    <= '0;
      if_pc     <= '0;
`ifdef FETCH_CTRL_DELAY_SLOT_EN
      pend      <= 1'b0;
      pend_pc   <= '0;
`endif
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      cnt       <= cnt_d;
      fetch_err <= err_d;
      if_valid  <= valid_d;
      if_ins    <= ins_d;
      if_pc     <= ipc_d;
`ifdef FETCH_CTRL_DELAY_SLOT_EN
      pend      <= pend_d;
      pend_pc   <= pend_pc_d;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a per-cycle reference model.
// Honours FETCH_CTRL_DELAY_SLOT_EN for delay-slot expectations.
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam int          TIMEOUT  = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack = 1'b0;
  logic [31:0] im_rdata = '0;
  logic        if_valid;
  logic [31:0] if_ins, if_pc;
  logic        id_ready = 1'b0;
  logic        br_taken = 1'b0;
  logic [15:0] br_imm = '0;
  logic        jmp = 1'b0;
  logic [25:0] jmp_target = '0;
  logic        jr = 1'b0;
  logic [31:0] jr_target = '0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        fetch_err;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  bit manual = 1'b0;
  bit ack_off = 1'b0;
  int req_cnt = 0;

  fetch_ctrl #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .im_req(im_req), .im_addr(im_addr),
    .im_ack(im_ack), .im_rdata(im_rdata),
    .if_valid(if_valid), .if_ins(if_ins), .if_pc(if_pc),
    .id_ready(id_ready), .br_taken(br_taken), .br_imm(br_imm),
    .jmp(jmp), .jmp_target(jmp_target),
    .jr(jr), .jr_target(jr_target),
    .flush(flush), .flush_pc(flush_pc),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expire(input string name);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Reference model: phase 0 gap, 1 requesting, 2 holding.
  int          ph = 0;
  int          waited = 0;
  logic [31:0] m_pc = RESET_PC;
  logic        m_valid = 0, m_err = 0, m_pend = 0;
  logic [31:0] m_ins = 0, m_ipc = 0, m_pend_pc = 0;

  function automatic logic [31:0] redirect_pc(input logic [31:0] p);
    logic [31:0] s;
    int off;
    s = p + 4;
    off = $signed(br_imm);
    if (jr) return jr_target & 32'hFFFF_FFFC;
    if (jmp) return {s[31:28], jmp_target, 2'b00};
    if (br_taken) return s + off * 4;
    return s;
  endfunction

  task automatic model_step();
    logic any;
    m_err = 0;
    any = jr | jmp | br_taken;
    if (!reset) begin
      ph = 0; m_pc = RESET_PC; m_valid = 0; m_ins = 0;
      m_ipc = 0; waited = 0; m_pend = 0;
    end else if (flush) begin
      ph = 1; m_pc = flush_pc & 32'hFFFF_FFFC;
      m_valid = 0; waited = 0; m_pend = 0;
    end else if (ph == 0) begin
      ph = 1; waited = 0;
    end else if (ph == 1) begin
      if (im_ack) begin
        m_ins = im_rdata; m_ipc = m_pc; m_valid = 1; ph = 2;
      end else begin
        waited++;
        if (waited == TIMEOUT) begin
          m_err = 1; ph = 0; waited = 0;
        end
      end
    end else if (id_ready) begin
      m_valid = 0; ph = 0;
`ifdef FETCH_CTRL_DELAY_SLOT_EN
      if (m_pend) begin
        m_pc = m_pend_pc; m_pend = 0;
      end else begin
        if (any) begin
          m_pend = 1; m_pend_pc = redirect_pc(m_ipc);
        end
        m_pc = m_ipc + 4;
      end
`else
      m_pc = redirect_pc(m_ipc);
`endif
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("im_req", 32'(im_req), 32'(ph == 1));
      chk("im_addr", im_addr, m_pc);
      chk("if_valid", 32'(if_valid), 32'(m_valid));
      chk("if_ins", if_ins, m_ins);
      chk("if_pc", if_pc, m_ipc);
      chk("fetch_err", 32'(fetch_err), 32'(m_err));
    end
  end

  // memory: ack on the second cycle of each request
  initial forever begin
    @(negedge clk);
    if (!manual) begin
      im_rdata = mem(im_addr);
      im_ack = im_req && !ack_off && req_cnt >= 1;
      req_cnt = im_req ? req_cnt + 1 : 0;
    end
  end

  task automatic wait_req(input logic [31:0] exp, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!im_req && n < 60);
    if (!im_req) begin
      expire(name);
      return;
    end
    chk(name, im_addr, exp);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (im_req && n < 60);
    if (im_req) expire({name, "_ack"});
    else chk({name, "_pc"}, if_pc, exp);
  endtask

  task automatic consume(input bit b, input logic [15:0] imm,
                         input bit j, input logic [25:0] jt,
                         input bit r, input logic [31:0] rt);
    int n;
    n = 0;
    while (!if_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!if_valid) expire("consume_wait");
    id_ready = 1; br_taken = b; br_imm = imm;
    jmp = j; jmp_target = jt; jr = r; jr_target = rt;
    @(negedge clk);
    id_ready = 0; br_taken = 0; jmp = 0; jr = 0;
  endtask

  task automatic redirect_check(input logic [31:0] ds,
                                input logic [31:0] tgt,
                                input string name);
`ifdef FETCH_CTRL_DELAY_SLOT_EN
    wait_req(ds, {name, "_slot"});
    consume(1, 16'h0010, 0, '0, 1, 32'h0000_8000);
`else
    if (ds == tgt) $display("note: slot equals target");
`endif
    wait_req(tgt, name);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk_en = 1;
    chk("rst_req", 32'(im_req), 32'd0);
    chk("rst_addr", im_addr, 32'h0000_3000);
    chk("rst_valid", 32'(if_valid), 32'd0);
    reset = 1;

    for (int i = 0; i < 5; i++) begin
      wait_req(32'h3000 + 32'(4 * i), "seq_addr");
      if (i == 2) begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("hold_req", 32'(im_req), 32'd0);
          chk("hold_pc", if_pc, 32'h0000_3008);
          chk("hold_ins", if_ins, 32'h3008_CFF7);
        end
      end
      if (i < 4) consume(0, '0, 0, '0, 0, '0);
      else consume(1, 16'hFFFC, 0, '0, 0, '0);
    end
    redirect_check(32'h3014, 32'h3004, "br_addr");

    consume(0, '0, 1, 26'h0000123, 1, 32'h0000_4003);
    redirect_check(32'h3008, 32'h4000, "jr_addr");
    consume(0, '0, 1, 26'h0000123, 0, '0);
    redirect_check(32'h4004, 32'h048C, "jmp_addr");

    consume(0, '0, 0, '0, 0, '0);
    ack_off = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!im_req && n < 60);
    n = 0;
    while (im_req && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("to_cycles", 32'(n), 32'd16);
    chk("to_err", 32'(fetch_err), 32'd1);
    @(negedge clk);
    chk("to_reissue", 32'(im_req), 32'd1);
    chk("to_addr", im_addr, 32'h0000_0490);
    chk("to_err_end", 32'(fetch_err), 32'd0);
    ack_off = 0;
    n = 0;
    while (!if_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("to_pc", if_pc, 32'h0000_0490);

    consume(0, '0, 0, '0, 0, '0);
    manual = 1;
    im_ack = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!im_req && n < 60);
    im_ack = 1; im_rdata = 32'hDEAD_BEEF;
    flush = 1; flush_pc = 32'h0000_0180;
    @(negedge clk);
    im_ack = 0; flush = 0;
    chk("fl_valid", 32'(if_valid), 32'd0);
    chk("fl_req", 32'(im_req), 32'd1);
    chk("fl_addr", im_addr, 32'h0000_0180);
    manual = 0;
    n = 0;
    while (!if_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("fl_pc", if_pc, 32'h0000_0180);
    id_ready = 1; jr = 1; jr_target = 32'h0000_4000;
    flush = 1; flush_pc = 32'h0000_0203;
    @(negedge clk);
    id_ready = 0; jr = 0; flush = 0;
    wait_req(32'h0000_0200, "fl_consume");

    consume(0, '0, 0, '0, 0, '0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!im_req && n < 60);
    manual = 1;
    im_ack = 1; im_rdata = 32'h1234_5678;
    reset = 0;
    @(negedge clk);
    im_ack = 0;
    chk("mr_req", 32'(im_req), 32'd0);
    chk("mr_addr", im_addr, 32'h0000_3000);
    chk("mr_valid", 32'(if_valid), 32'd0);
    chk("mr_ins", if_ins, 32'd0);
    reset = 1;
    manual = 0;
    wait_req(32'h0000_3000, "mr_restart");

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not end");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $finish;
  end

endmodule
